// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns PC/IR, fetches words from imem over req/ack for the control FSM.
// Latency: write_ir edge to W_IR_valid is 2 edges minimum; +1 edge per memory wait cycle.
// Backpressure: waits on imem_ack up to MAX_WAIT+1 req cycles, then drops req and sets fetch_fault.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   write_ir, write_pc   FSM fetch request and PC write strobe
//   pc_s                 PC source: 0 sequential, 1 B_data, 2 F_data, 3 hold
//   B_data, F_data       redirect targets (BX / B,BL)
//   imem_req/addr        registered memory request and address
//   imem_rdata/ack       memory response
//   PC, IR               program counter and instruction register
//   W_IR_valid           one-cycle pulse when IR holds a freshly fetched word
//   fetch_fault          sticky timeout flag
//   fetch_count          completed fetches, free-running 16-bit
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_ir,
  input  logic        write_pc,
  input  logic [1:0]  pc_s,
  input  logic [31:0] B_data,
  input  logic [31:0] F_data,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic        W_IR_valid,
  output logic        fetch_fault,
  output logic [15:0] fetch_count
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  wcnt, wcnt_nx;
  logic        req_nx, valid_nx, fault_nx;
  logic [31:0] addr_nx, pc_nx, ir_nx;
  logic [15:0] cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= F_IDLE;
      wcnt        <= 8'd0;
      imem_req    <= 1'b0;
      imem_addr   <= 32'd0;
      PC          <= RESET_PC;
      IR          <= 32'd0;
      W_IR_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      state       <= state_nx;
      wcnt        <= wcnt_nx;
      imem_req    <= req_nx;
      imem_addr   <= addr_nx;
      PC          <= pc_nx;
      IR          <= ir_nx;
      W_IR_valid  <= valid_nx;
      fetch_fault <= fault_nx;
      fetch_count <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    req_nx   = imem_req;
    addr_nx  = imem_addr;
    pc_nx    = PC;
    ir_nx    = IR;
    valid_nx = 1'b0;
    fault_nx = fetch_fault;
    cnt_nx   = fetch_count;

    case (state)
      F_IDLE: begin
        // Redirect resolves before the fetch decision so a same-cycle
        // write_ir issues to the new target.
        if (write_pc) begin
          case (pc_s)
            2'd1:    pc_nx = B_data;
            2'd2:    pc_nx = F_data;
            default: pc_nx = PC;
          endcase
        end
        if (write_ir) begin
          req_nx   = 1'b1;
          addr_nx  = pc_nx;
          wcnt_nx  = 8'd0;
          state_nx = F_WAIT;
        end
      end

      F_WAIT: begin
        // ack is checked first so an ack on the last allowed cycle still completes.
        if (imem_ack) begin
          ir_nx    = imem_rdata;
          pc_nx    = PC + 32'd4;
          valid_nx = 1'b1;
          req_nx   = 1'b0;
          cnt_nx   = fetch_count + 16'd1;
          state_nx = F_DONE;
        end else if (wcnt == MAX_WAIT_C) begin
          // PC is left alone so the next write_ir retries the same address.
          req_nx   = 1'b0;
          fault_nx = 1'b1;
          state_nx = F_IDLE;
        end else begin
          wcnt_nx = wcnt + 8'd1;
        end
      end

      F_DONE: begin
        // The FSM is still leaving S0 here; its strobes are not acted on.
        state_nx = F_IDLE;
      end

      default: begin
        state_nx = F_IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

endmodule
